// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO fed by MMIO store bytes and drained
// by a registered-output bit serialiser with configurable data/parity/stop format.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned BW  = 4;

  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  // FIFO storage and pointers (one bit wider than the index)
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [AW:0]       level_w;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              ovf_q, ovf_d;

  // Serialiser state
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  assign level_w = wptr_q - rptr_q;
  assign full    = (level_w == LVL_FULL);
  assign empty   = (level_w == '0);
  assign level   = level_w;
  assign head    = mem_q[rptr_q[AW-1:0]];
  // full is taken from registered pointers, so a same-edge pop never frees room
  assign push    = wr_en && !full;

  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE) || !empty;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    bit_d     = bit_q;
    sh_d      = sh_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    baud_last = (cnt_q == CNT_LAST);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          par_d   = (^head) ^ ODD;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = sh_q[0];
        end
      end
      S_DATA: begin
        if (baud_last) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_ONE;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      S_PAR: begin
        if (baud_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            // Chain straight into the next start bit when data is waiting
            if (!empty) begin
              pop     = 1'b1;
              sh_d    = head;
              par_d   = (^head) ^ ODD;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations share one clock; a
// byte scoreboard is filled on write and drained by a cycle-exact frame checker.
module tb_uart_tx_fifo;

  localparam int DIV = 10;

  logic       clk;
  logic       RST;
  logic [3:0] wr_en_v;
  logic [7:0] wr_data;
  logic       ovf_clr;
  int         sel;

  logic       tx0, full0, empty0, busy0, ovf0;
  logic [2:0] level0;
  logic       tx1, full1, empty1, busy1, ovf1;
  logic [4:0] level1;
  logic       tx2, full2, empty2, busy2, ovf2;
  logic [4:0] level2;
  logic       tx3, full3, empty3, busy3, ovf3;
  logic [4:0] level3;

  logic        tx_m;
  logic [31:0] level_m;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_W(8), .FIFO_DEPTH(4),
                 .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(clk), .RST(RST), .wr_en(wr_en_v[0]), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx0), .full(full0), .empty(empty0), .level(level0), .busy(busy0), .overflow(ovf0));

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_W(8), .FIFO_DEPTH(16),
                 .PARITY(1), .STOP_BITS(1)) u1 (
    .CLK(clk), .RST(RST), .wr_en(wr_en_v[1]), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx1), .full(full1), .empty(empty1), .level(level1), .busy(busy1), .overflow(ovf1));

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_W(8), .FIFO_DEPTH(16),
                 .PARITY(2), .STOP_BITS(1)) u2 (
    .CLK(clk), .RST(RST), .wr_en(wr_en_v[2]), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx2), .full(full2), .empty(empty2), .level(level2), .busy(busy2), .overflow(ovf2));

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_W(7), .FIFO_DEPTH(16),
                 .PARITY(0), .STOP_BITS(2)) u3 (
    .CLK(clk), .RST(RST), .wr_en(wr_en_v[3]), .wr_data(wr_data[6:0]), .ovf_clr(ovf_clr),
    .tx(tx3), .full(full3), .empty(empty3), .level(level3), .busy(busy3), .overflow(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      0:       begin tx_m = tx0; level_m = {29'b0, level0}; end
      1:       begin tx_m = tx1; level_m = {27'b0, level1}; end
      2:       begin tx_m = tx2; level_m = {27'b0, level2}; end
      default: begin tx_m = tx3; level_m = {27'b0, level3}; end
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks that tx holds val for n consecutive cycles; reports the first wrong sample
  task automatic chk_bits(input string tag, input logic val, input int n);
    logic seen;
    logic bad;
    seen = 1'b0;
    bad  = val;
    repeat (n) begin
      @(negedge clk);
      if (tx_m !== val && !seen) begin
        seen = 1'b1;
        bad  = tx_m;
      end
    end
    chk(tag, 32'(bad), 32'(val));
  endtask

  task automatic rx_frame(input int dw, input int par, input int sb, input int max_wait);
    int         w;
    logic [7:0] e;
    logic       p;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx_m !== 1'b0 && w < max_wait);
    chk("start_edge", 32'(tx_m), 32'd0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    chk_bits("start", 1'b0, DIV - 1);
    p = (par == 2);
    for (int i = 0; i < dw; i++) begin
      chk_bits($sformatf("data[%0d] of 0x%0h", i, e), e[i], DIV);
      p = p ^ e[i];
    end
    if (par != 0) chk_bits($sformatf("parity of 0x%0h", e), p, DIV);
    for (int i = 0; i < sb; i++) chk_bits("stop", 1'b1, DIV);
  endtask

  task automatic wr1(input int s, input logic [7:0] d);
    @(negedge clk);
    wr_en_v[s] = 1'b1;
    wr_data    = d;
    exp_q.push_back((s == 3) ? (d & 8'h7f) : d);
    @(negedge clk);
    wr_en_v[s] = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_m !== 1'b1) lows++;
    end
    chk(tag, 32'(lows), 32'd0);
  endtask

  task automatic burst4(input int s, input int dw, input int sb);
    fork
      begin
        int pk;
        pk = 0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (int'(level_m) > pk) pk = int'(level_m);
          wr_en_v[s] = 1'b1;
          wr_data    = 8'(8'h41 + i);
          exp_q.push_back((s == 3) ? (8'(8'h41 + i) & 8'h7f) : 8'(8'h41 + i));
        end
        repeat (4) begin
          @(negedge clk);
          wr_en_v[s] = 1'b0;
          if (int'(level_m) > pk) pk = int'(level_m);
        end
        chk($sformatf("burst_level_peak_u%0d", s), 32'(pk), 32'd3);
      end
      begin
        rx_frame(dw, 0, sb, 5);
        repeat (3) rx_frame(dw, 0, sb, 1);
      end
    join
  endtask

  initial begin
    RST     = 1'b1;
    wr_en_v = '0;
    wr_data = '0;
    ovf_clr = 1'b0;
    sel     = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_level", {29'b0, level0}, 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_overflow", 32'(ovf0), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, start bit must appear one edge after the write
    @(negedge clk);
    wr_en_v[0] = 1'b1;
    wr_data    = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    chk("wr_empty", 32'(empty0), 32'd0);
    chk("wr_level", {29'b0, level0}, 32'd1);
    chk("wr_busy", 32'(busy0), 32'd1);
    rx_frame(8, 0, 1, 1);
    chk("busy_last_stop", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("busy_fall", 32'(busy0), 32'd0);
    chk("idle_empty", 32'(empty0), 32'd1);
    chk("idle_tx", 32'(tx0), 32'd1);

    // Parity formats; busy falling right after the last stop bit pins the frame length
    sel = 1;
    wr1(1, 8'h55);
    rx_frame(8, 1, 1, 1);
    @(negedge clk);
    chk("even55_busy_fall", 32'(busy1), 32'd0);
    wr1(1, 8'h07);
    rx_frame(8, 1, 1, 1);
    @(negedge clk);
    chk("even07_busy_fall", 32'(busy1), 32'd0);
    sel = 2;
    wr1(2, 8'h55);
    rx_frame(8, 2, 1, 1);
    @(negedge clk);
    chk("odd55_busy_fall", 32'(busy2), 32'd0);

    // Back-to-back bursts, frames must be contiguous
    sel = 0;
    burst4(0, 8, 1);
    @(negedge clk);
    chk("burst_u0_busy_fall", 32'(busy0), 32'd0);
    sel = 3;
    burst4(3, 7, 2);
    @(negedge clk);
    chk("burst_u3_busy_fall", 32'(busy3), 32'd0);

    // Full / overflow on the 4-deep instance
    sel = 0;
    repeat (3) @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 5) begin
            chk("ovf_full_before", 32'(full0), 32'd1);
            chk("ovf_level_before", {29'b0, level0}, 32'd4);
            chk("ovf_flag_before", 32'(ovf0), 32'd0);
          end
          wr_en_v[0] = 1'b1;
          wr_data    = 8'(8'h61 + i);
          if (i < 5) exp_q.push_back(8'(8'h61 + i));
        end
        @(negedge clk);
        wr_en_v[0] = 1'b0;
        chk("ovf_flag_set", 32'(ovf0), 32'd1);
        chk("ovf_level_after", {29'b0, level0}, 32'd4);
        chk("ovf_full_after", 32'(full0), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(ovf0), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf0), 32'd0);
      end
      begin
        rx_frame(8, 0, 1, 5);
        repeat (4) rx_frame(8, 0, 1, 1);
      end
    join
    quiet("ovf_no_sixth_frame", 150);
    chk("ovf_busy_end", 32'(busy0), 32'd0);

    // Wrap-around: 12 bytes through a 4-deep FIFO, kept about half full
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          int w;
          w = 0;
          @(negedge clk);
          while (level_m >= 32'd2 && w < 400) begin
            @(negedge clk);
            w++;
          end
          chk("wrap_fill_wait", 32'(w < 400), 32'd1);
          wr_en_v[0] = 1'b1;
          wr_data    = 8'(8'h80 + i * 13);
          exp_q.push_back(8'(8'h80 + i * 13));
          @(negedge clk);
          wr_en_v[0] = 1'b0;
        end
      end
      begin
        repeat (12) rx_frame(8, 0, 1, 300);
      end
    join
    chk("wrap_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    repeat (3) @(negedge clk);
    @(negedge clk);
    wr_en_v[0] = 1'b1;
    wr_data    = 8'hA5;
    @(negedge clk);
    wr_data = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    chk("rstmid_level_queued", {29'b0, level0}, 32'd2);
    repeat (42) @(negedge clk);
    chk("rstmid_bit3", 32'(tx0), 32'd0);
    RST = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", 32'(tx0), 32'd1);
    chk("rstmid_empty", 32'(empty0), 32'd1);
    chk("rstmid_level", {29'b0, level0}, 32'd0);
    chk("rstmid_busy", 32'(busy0), 32'd0);
    RST = 1'b0;
    quiet("rstmid_no_frames", 300);
    chk("rstmid_empty_after", 32'(empty0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
